// File: rtl/sram_stream_reader.sv
// sram_stream_reader: walks consecutive SRAM addresses through one arbiter read slot into a FWFT FIFO.
// Define SRAM_STREAM_READER_LOOP_EN to repeat the pass until stop or rst.
module sram_stream_reader #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int FIFO_DEPTH        = 4,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
    input  logic [COUNT_WIDTH-1:0]       word_count,
    input  logic                         stop,
    output logic                         read_request,
    output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
    input  logic                         read_finished_strobe,
    input  logic [DATA_BUS_WIDTH-1:0]    read_data,
    output logic                         out_valid,
    output logic [DATA_BUS_WIDTH-1:0]    out_data,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done_strobe
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]       DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] ONE_C     = COUNT_WIDTH'(1);
    localparam logic [ADDRESS_BUS_WIDTH-1:0] A_ONE_C = ADDRESS_BUS_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t                         r_state, w_state_next;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_addr, w_addr_next;
    logic [COUNT_WIDTH-1:0]         r_remaining, w_remaining_next;
    logic                           r_stop_pending, w_stop_pending_next;
    logic                           r_done, w_done_next;

    logic [DATA_BUS_WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]               r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]               r_count, w_count_next;
    logic                           w_push, w_pop, w_has_room, w_room_after;

    // Output stream: a word moves to the consumer in any cycle where out_valid && out_ready.
    assign out_valid    = (r_count != '0);
    assign out_data     = out_valid ? r_mem[r_rd_ptr] : '0;
    assign w_pop        = out_valid && out_ready;
    assign w_push       = (r_state == S_REQ) && read_finished_strobe;
    assign w_has_room   = (r_count < DEPTH_C);
    assign w_room_after = (w_count_next < DEPTH_C);

    // Dropped combinationally on the strobe so the arbiter never sees a second request for the same word.
    assign read_request = (r_state == S_REQ) && !read_finished_strobe && !rst;
    assign read_address = r_addr;
    assign busy         = (r_state != S_IDLE);
    assign done_strobe  = r_done;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CNT_W'(1);
    end

`ifdef SRAM_STREAM_READER_LOOP_EN
    logic [ADDRESS_BUS_WIDTH-1:0] r_loop_addr;
    logic [COUNT_WIDTH-1:0]       r_loop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loop_addr  <= '0;
            r_loop_count <= '0;
        end else if ((r_state == S_IDLE) && start && (word_count != '0)) begin
            r_loop_addr  <= base_address;
            r_loop_count <= word_count;
        end
    end
`endif

    always_comb begin
        w_state_next        = r_state;
        w_addr_next         = r_addr;
        w_remaining_next    = r_remaining;
        w_stop_pending_next = r_stop_pending;
        w_done_next         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        w_addr_next         = base_address;
                        w_remaining_next    = word_count;
                        w_stop_pending_next = 1'b0;
                        w_state_next        = w_has_room ? S_REQ : S_HOLD;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end else if (stop) begin
                    w_done_next = 1'b1;
                end
            end
            S_REQ: begin
                if (stop)
                    w_stop_pending_next = 1'b1;
                if (read_finished_strobe) begin
                    w_addr_next      = r_addr + A_ONE_C;
                    w_remaining_next = r_remaining - ONE_C;
                    if (stop || r_stop_pending) begin
                        w_done_next         = 1'b1;
                        w_stop_pending_next = 1'b0;
                        w_state_next        = S_IDLE;
                    end else if (r_remaining == ONE_C) begin
                        w_done_next = 1'b1;
`ifdef SRAM_STREAM_READER_LOOP_EN
                        w_addr_next      = r_loop_addr;
                        w_remaining_next = r_loop_count;
                        w_state_next     = w_room_after ? S_REQ : S_HOLD;
`else
                        w_state_next     = S_IDLE;
`endif
                    end else begin
                        w_state_next = w_room_after ? S_REQ : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (stop) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_has_room) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_stop_pending <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_addr         <= w_addr_next;
            r_remaining    <= w_remaining_next;
            r_stop_pending <= w_stop_pending_next;
            r_done         <= w_done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= read_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end
endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: arbiter bus model, random consumer, queue scoreboard.
// Build with SRAM_STREAM_READER_LOOP_EN defined to exercise the looping variant instead.
module tb_sram_stream_reader;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_address;
    logic [15:0] word_count;
    logic        stop;
    logic        read_request;
    logic [15:0] read_address;
    logic        read_finished_strobe;
    logic [15:0] read_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done_strobe;

    sram_stream_reader dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .base_address         (base_address),
        .word_count           (word_count),
        .stop                 (stop),
        .read_request         (read_request),
        .read_address         (read_address),
        .read_finished_strobe (read_finished_strobe),
        .read_data            (read_data),
        .out_valid            (out_valid),
        .out_data             (out_data),
        .out_ready            (out_ready),
        .busy                 (busy),
        .done_strobe          (done_strobe)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;
    int pop_cnt  = 0;
    int busy_drop = 0;
    bit loop_watch = 0;

    int          ready_mode;   // 0 low, 1 high, 2 random
    bit          bus_en;
    int          bus_lat;      // 0 = random 1..4
    logic        man_strobe;
    logic [15:0] man_data;

    logic [15:0] exp_q[$];
    logic [15:0] exp_addr_q[$];

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a pass reads base+i (mod 2^16); the bus returns addr ^ 0xA5A5.
    task automatic push_exp(input logic [15:0] b, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(a ^ 16'hA5A5);
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] n, input int npush);
        @(posedge clk); #1;
        start        = 1'b1;
        base_address = b;
        word_count   = n;
        push_exp(b, npush);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done_cnt), 32'(target));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        ready_mode = 1;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Arbiter bus model: accepts a request, holds it for the latency, returns one strobe.
    initial begin : bus_model
        bit          pend;
        int          lat;
        logic [15:0] pend_addr;
        pend = 0;
        lat = 0;
        pend_addr = '0;
        read_finished_strobe = 1'b0;
        read_data = '0;
        forever begin
            @(negedge clk);
            if (bus_en && !rst) begin
                if (read_finished_strobe) begin
                    check("req_low_on_strobe", 32'(read_request), 32'd0);
                end else if (pend) begin
                    check("req_hold", 32'({read_request, read_address}), 32'({1'b1, pend_addr}));
                end else if (read_request) begin
                    acc_cnt++;
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_req actual=0x%0h expected=none", read_address);
                    end else begin
                        check("req_addr", 32'(read_address), 32'(exp_addr_q.pop_front()));
                    end
                    pend = 1;
                    pend_addr = read_address;
                    lat = (bus_lat == 0) ? int'($urandom_range(1, 4)) : bus_lat;
                end
            end
            @(posedge clk); #1;
            if (bus_en) begin
                read_finished_strobe = 1'b0;
                if (pend) begin
                    lat--;
                    if (lat == 0) begin
                        read_finished_strobe = 1'b1;
                        read_data = pend_addr ^ 16'hA5A5;
                        pend = 0;
                    end
                end
            end else begin
                read_finished_strobe = man_strobe;
                read_data = man_data;
                pend = 0;
            end
        end
    end

    // consumer driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done_strobe)
                    done_cnt++;
                if (loop_watch && !busy)
                    busy_drop++;
                if (out_valid && out_ready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=0x%0h expected=none", out_data);
                    end else begin
                        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : main
        int d0;
        int a0;
        int p0;
        int n;
        logic [15:0] b;
        logic [15:0] c;
        rst = 1'b1;
        start = 1'b0;
        base_address = '0;
        word_count = '0;
        stop = 1'b0;
        ready_mode = 1;
        bus_en = 1;
        bus_lat = 2;
        man_strobe = 1'b0;
        man_data = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read_request", 32'(read_request), 32'd0);
        check("rst_read_address", 32'(read_address), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_strobe), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

`ifdef SRAM_STREAM_READER_LOOP_EN
        d0 = done_cnt;
        a0 = acc_cnt;
        p0 = pop_cnt;
        do_start(16'h0040, 16'd2, 2);
        push_exp(16'h0040, 2);
        push_exp(16'h0040, 2);
        push_exp(16'h0040, 2);
        loop_watch = 1;
        wait_done(d0 + 3, 300, "loop_three_passes");
        loop_watch = 0;
        check("loop_busy_held", 32'(busy_drop), 32'd0);
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done(d0 + 4, 50, "loop_stop_done");
        repeat (10) @(negedge clk);
        check("loop_idle", 32'(busy), 32'd0);
        check("loop_min_reads", 32'(acc_cnt - a0 >= 6), 32'd1);
        check("loop_words_match", 32'(pop_cnt - p0), 32'(acc_cnt - a0));
        exp_q.delete();
        exp_addr_q.delete();
`else
        // basic pass crossing 0x3FFF -> 0x4000
        d0 = done_cnt;
        do_start(16'h3FFE, 16'd3, 3);
        wait_done(d0 + 1, 100, "basic_done");
        drain("basic_drain");
        repeat (5) @(negedge clk);
        check("basic_one_done", 32'(done_cnt), 32'(d0 + 1));
        check("basic_idle", 32'(busy), 32'd0);

        // address wrap
        d0 = done_cnt;
        do_start(16'hFFFF, 16'd2, 2);
        wait_done(d0 + 1, 100, "wrap_done");
        drain("wrap_drain");

        // backpressure: FIFO fills after four reads, extra start ignored while busy
        ready_mode = 0;
        d0 = done_cnt;
        a0 = acc_cnt;
        do_start(16'h0100, 16'd10, 10);
        repeat (40) @(negedge clk);
        check("bp_reads", 32'(acc_cnt - a0), 32'd4);
        check("bp_hold_req", 32'(read_request), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_valid", 32'(out_valid), 32'd1);
        do_start(16'h7777, 16'd5, 0);
        repeat (5) @(negedge clk);
        check("bp_start_ignored", 32'(acc_cnt - a0), 32'd4);
        ready_mode = 1;
        wait_done(d0 + 1, 200, "bp_done");
        drain("bp_drain");
        check("bp_total_reads", 32'(acc_cnt - a0), 32'd10);

        // stop while holding
        ready_mode = 0;
        a0 = acc_cnt;
        do_start(16'h2000, 16'd6, 4);
        repeat (30) @(negedge clk);
        check("hold_reads", 32'(acc_cnt - a0), 32'd4);
        d0 = done_cnt;
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_stop_done", 32'(done_cnt), 32'(d0 + 1));
        check("hold_stop_idle", 32'(busy), 32'd0);
        drain("hold_stop_drain");
        check("hold_stop_no_req", 32'(acc_cnt - a0), 32'd4);

        // stop while a read is outstanding: the word is still delivered
        bus_lat = 3;
        d0 = done_cnt;
        a0 = acc_cnt;
        do_start(16'h0A00, 16'd5, 1);
        n = 0;
        while (!read_request && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done(d0 + 1, 50, "req_stop_done");
        drain("req_stop_drain");
        repeat (10) @(negedge clk);
        check("req_stop_one_read", 32'(acc_cnt - a0), 32'd1);
        check("req_stop_idle", 32'(busy), 32'd0);
        check("req_stop_one_done", 32'(done_cnt), 32'(d0 + 1));

        // zero word count
        a0 = acc_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        base_address = 16'h5555;
        word_count = 16'd0;
        @(negedge clk);
        check("zero_done_early", 32'(done_strobe), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done_next", 32'(done_strobe), 32'd1);
        check("zero_no_req", 32'(read_request), 32'd0);
        repeat (5) @(negedge clk);
        check("zero_no_reads", 32'(acc_cnt - a0), 32'd0);

        // randomized passes; FIFO contents carry over between passes
        bus_lat = 0;
        ready_mode = 2;
        for (int k = 0; k < 8; k++) begin
            b = 16'($urandom_range(0, 65535));
            c = 16'($urandom_range(1, 12));
            d0 = done_cnt;
            do_start(b, c, int'(c));
            wait_done(d0 + 1, 600, "rand_done");
        end
        drain("rand_drain");

        // reset mid-read, then a stale strobe from the abandoned read
        bus_lat = 2;
        @(negedge clk);
        bus_en = 0;
        do_start(16'h1234, 16'd3, 0);
        n = 0;
        while (!read_request && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstm_req_seen", 32'(read_request), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstm_req_drop", 32'(read_request), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        man_strobe = 1'b1;
        man_data = 16'hBEEF;
        @(negedge clk);
        man_strobe = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rstm_no_push", 32'(out_valid), 32'd0);
        end
        check("rstm_idle", 32'(busy), 32'd0);
        bus_en = 1;
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
